// File: rtl/tdc_measure_ctrl.sv
// tdc_measure_ctrl
// Arms on request, times the interval between rising edges of the (already
// synchronized) start and stop events in coarse clock cycles, strobes the
// delay line for its fine code and hands one {coarse, fine, err} result to
// the readout logic over a valid/ready handshake.
module tdc_measure_ctrl #(
  parameter int COARSE_W   = 16,
  parameter int FINE_W     = 6,
  parameter int TIMEOUT    = 1000,
  parameter int VALID_WAIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                start_evt,
  input  logic                stop_evt,
  output logic                dl_sample,
  input  logic                dl_valid,
  input  logic [FINE_W-1:0]   dl_fine,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [COARSE_W-1:0] result_coarse,
  output logic [FINE_W-1:0]   result_fine,
  output logic [1:0]          result_err
);

  // Wait counter only has to reach VALID_WAIT-1.
  localparam int WAIT_W = (VALID_WAIT > 1) ? $clog2(VALID_WAIT) : 1;

  localparam logic [COARSE_W-1:0] COARSE_LAST = COARSE_W'(TIMEOUT - 1);
  localparam logic [COARSE_W-1:0] COARSE_ONE  = COARSE_W'(1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(VALID_WAIT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_ONE    = WAIT_W'(1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NO_STOP = 2'b01;
  localparam logic [1:0] ERR_NO_FINE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_COUNT      = 3'd2,
    S_SAMPLE     = 3'd3,
    S_WAIT_VALID = 3'd4,
    S_RESULT     = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                start_prev_q, start_prev_d;
  logic                stop_prev_q, stop_prev_d;
  logic                start_edge, stop_edge;

  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic [COARSE_W-1:0] res_coarse_q, res_coarse_d;
  logic [FINE_W-1:0]   res_fine_q, res_fine_d;
  logic [1:0]          res_err_q, res_err_d;

  // Event history follows the lines in every state; the reset value of 1
  // keeps a line that is already high at reset release from being an edge.
  always_comb begin
    start_prev_d = start_evt;
    stop_prev_d  = stop_evt;
    start_edge   = start_evt & ~start_prev_q;
    stop_edge    = stop_evt & ~stop_prev_q;
  end

  // Sequencer: next state, coarse/wait counters and result capture.
  always_comb begin
    state_d      = state_q;
    coarse_d     = coarse_q;
    wait_d       = wait_q;
    res_coarse_d = res_coarse_q;
    res_fine_d   = res_fine_q;
    res_err_d    = res_err_q;

    case (state_q)
      S_IDLE: begin
        // Previous result stays visible on the outputs while idle.
        if (arm) begin
          state_d = S_WAIT_START;
        end
      end

      S_WAIT_START: begin
        // Stop edges are meaningless before the interval has begun.
        if (start_edge) begin
          state_d  = S_COUNT;
          coarse_d = '0;
        end
      end

      S_COUNT: begin
        // A stop edge takes priority over the timeout in the same cycle.
        if (stop_edge) begin
          state_d = S_SAMPLE;
        end else if (coarse_q == COARSE_LAST) begin
          state_d      = S_RESULT;
          res_coarse_d = coarse_q;
          res_fine_d   = '0;
          res_err_d    = ERR_NO_STOP;
        end else begin
          coarse_d = coarse_q + COARSE_ONE;
        end
      end

      S_SAMPLE: begin
        // dl_sample is decoded from this state; one cycle only.
        state_d = S_WAIT_VALID;
        wait_d  = '0;
      end

      S_WAIT_VALID: begin
        if (dl_valid) begin
          state_d      = S_RESULT;
          res_coarse_d = coarse_q;
          res_fine_d   = dl_fine;
          res_err_d    = ERR_OK;
        end else if (wait_q == WAIT_LAST) begin
          state_d      = S_RESULT;
          res_coarse_d = coarse_q;
          res_fine_d   = '0;
          res_err_d    = ERR_NO_FINE;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      S_RESULT: begin
        // result_valid is high throughout this state, so ready alone closes it.
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, edge history and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      coarse_q     <= '0;
      wait_q       <= '0;
      res_coarse_q <= '0;
      res_fine_q   <= '0;
      res_err_q    <= ERR_OK;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      coarse_q     <= coarse_d;
      wait_q       <= wait_d;
      res_coarse_q <= res_coarse_d;
      res_fine_q   <= res_fine_d;
      res_err_q    <= res_err_d;
    end
  end

  // Status outputs are Moore decodes; result fields come straight from flops.
  always_comb begin
    dl_sample     = (state_q == S_SAMPLE);
    busy          = (state_q != S_IDLE);
    result_valid  = (state_q == S_RESULT);
    result_coarse = res_coarse_q;
    result_fine   = res_fine_q;
    result_err    = res_err_q;
  end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Self-checking bench for tdc_measure_ctrl. Inputs change on the falling
// edge; outputs are read on the falling edge, i.e. half a cycle after the
// rising edge that produced them. Expected results come from interval
// arithmetic on the event timing, not from the design's state machine.
module tb_tdc_measure_ctrl;

  localparam int COARSE_W   = 16;
  localparam int FINE_W     = 6;
  localparam int TIMEOUT    = 20;
  localparam int VALID_WAIT = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                arm;
  logic                start_evt;
  logic                stop_evt;
  logic                dl_sample;
  logic                dl_valid;
  logic [FINE_W-1:0]   dl_fine;
  logic                busy;
  logic                result_valid;
  logic                result_ready;
  logic [COARSE_W-1:0] result_coarse;
  logic [FINE_W-1:0]   result_fine;
  logic [1:0]          result_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tdc_measure_ctrl #(
    .COARSE_W  (COARSE_W),
    .FINE_W    (FINE_W),
    .TIMEOUT   (TIMEOUT),
    .VALID_WAIT(VALID_WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .start_evt    (start_evt),
    .stop_evt     (stop_evt),
    .dl_sample    (dl_sample),
    .dl_valid     (dl_valid),
    .dl_fine      (dl_fine),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_coarse(result_coarse),
    .result_fine  (result_fine),
    .result_err   (result_err)
  );

  // Reference: start edge at relative cycle 0, stop edge at cycle d (0 = none),
  // delay line answers lat cycles after the strobe. Cycles are relative to
  // the start edge.
  function automatic void predict(input int d, input int lat, input int fine,
                                  output int exp_coarse, output int exp_fine,
                                  output int exp_err, output int exp_sample,
                                  output int exp_rv);
    if (d >= 1 && d <= TIMEOUT) begin
      exp_coarse = d - 1;
      exp_sample = d + 1;
      if (lat <= VALID_WAIT) begin
        exp_err  = 0;
        exp_fine = fine;
        exp_rv   = d + 2 + lat;
      end else begin
        exp_err  = 2;
        exp_fine = 0;
        exp_rv   = d + 2 + VALID_WAIT;
      end
    end else begin
      exp_coarse = TIMEOUT - 1;
      exp_fine   = 0;
      exp_err    = 1;
      exp_sample = -1;
      exp_rv     = TIMEOUT + 1;
    end
  endfunction

  // One complete measurement: arm, optional idle cycles in WAIT_START, start
  // edge, stop edge d cycles later, delay line reply, hold, handshake.
  task automatic do_measure(input string name, input int d, input int fine,
                            input int lat, input int hold, input int pre,
                            input bit stop_at0, input bit skip_arm);
    int ec, ef, ee, es, erv;
    int sample_at, rv_at, bad_sample, bad_hold;
    logic [COARSE_W-1:0] held_coarse;
    logic [FINE_W-1:0]   held_fine;
    logic [1:0]          held_err;
    predict(d, lat, fine, ec, ef, ee, es, erv);

    if (!skip_arm) begin
      start_evt = 1'b0;
      stop_evt  = 1'b0;
      arm       = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      checks++;
      if (busy !== 1'b1) $display("FAIL %s busy_after_arm: got %b want 1", name, busy);
      else passed++;
    end

    for (int p = 0; p < pre; p++) begin
      start_evt = 1'b0;
      stop_evt  = 1'($urandom_range(0, 1));
      dl_valid  = 1'($urandom_range(0, 1));
      dl_fine   = FINE_W'($urandom);
      @(negedge clk);
    end

    sample_at  = -1;
    rv_at      = -1;
    bad_sample = 0;
    for (int k = 0; k < 64; k++) begin
      if (dl_sample === 1'b1) begin
        if (sample_at < 0) sample_at = k;
        if (k != es) bad_sample++;
      end else if (k == es) begin
        bad_sample++;
      end
      if (result_valid === 1'b1) begin
        rv_at = k;
        break;
      end
      start_evt = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (k == 0)               stop_evt = 1'(stop_at0 && (d != 1));
      else if (d >= 1 && k < d) stop_evt = 1'b0;
      else if (d >= 1 && k == d) stop_evt = 1'b1;
      else if (d >= 1)          stop_evt = 1'($urandom_range(0, 1));
      else                      stop_evt = 1'b0;
      if (sample_at >= 0 && k > sample_at) begin
        dl_valid = (k == sample_at + lat);
        dl_fine  = dl_valid ? FINE_W'(fine) : FINE_W'($urandom);
      end else begin
        dl_valid = 1'($urandom_range(0, 1));
        dl_fine  = FINE_W'($urandom);
      end
      @(negedge clk);
    end

    checks++;
    if (rv_at != erv) $display("FAIL %s result_valid_cycle: got %0d want %0d", name, rv_at, erv);
    else passed++;
    checks++;
    if (bad_sample != 0) $display("FAIL %s dl_sample_timing: got %0d bad cycles want 0 (strobe at %0d)", name, bad_sample, es);
    else passed++;
    checks++;
    if (result_coarse !== COARSE_W'(ec)) $display("FAIL %s coarse: got %0d want %0d", name, result_coarse, ec);
    else passed++;
    checks++;
    if (result_fine !== FINE_W'(ef)) $display("FAIL %s fine: got %0d want %0d", name, result_fine, ef);
    else passed++;
    checks++;
    if (result_err !== 2'(ee)) $display("FAIL %s err: got %0d want %0d", name, result_err, ee);
    else passed++;

    held_coarse = result_coarse;
    held_fine   = result_fine;
    held_err    = result_err;
    bad_hold    = 0;
    for (int i = 0; i < hold; i++) begin
      result_ready = 1'b0;
      arm          = (i % 2 == 0);
      start_evt    = 1'($urandom_range(0, 1));
      stop_evt     = 1'($urandom_range(0, 1));
      dl_valid     = 1'($urandom_range(0, 1));
      dl_fine      = FINE_W'($urandom);
      @(negedge clk);
      if (result_valid !== 1'b1 || busy !== 1'b1 || result_coarse !== held_coarse ||
          result_fine !== held_fine || result_err !== held_err) bad_hold++;
    end
    arm          = 1'b0;
    result_ready = 1'b1;
    start_evt    = 1'b0;
    stop_evt     = 1'b0;
    dl_valid     = 1'b0;
    @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (bad_hold != 0) $display("FAIL %s hold_stable: got %0d unstable cycles want 0", name, bad_hold);
    else passed++;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after_handshake: got valid=%b busy=%b want 0 0", name, result_valid, busy);
    else passed++;

    $display("meas %-12s d=%0d lat=%0d hold=%0d -> coarse=%0d fine=%0d err=%0d valid_at=%0d",
             name, d, lat, hold, result_coarse_prev(held_coarse), held_fine, held_err, rv_at);
  endtask

  function automatic int result_coarse_prev(input logic [COARSE_W-1:0] c);
    return int'(c);
  endfunction

  task automatic test_reset();
    int bad;
    rst          = 1'b1;
    arm          = 1'b1;
    start_evt    = 1'b1;
    stop_evt     = 1'b0;
    dl_valid     = 1'b0;
    dl_fine      = '0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dl_sample, busy, result_valid, result_coarse, result_fine, result_err} !== '0)
      $display("FAIL reset_outputs: got sample=%b busy=%b valid=%b coarse=%0d fine=%0d err=%0d want all 0",
               dl_sample, busy, result_valid, result_coarse, result_fine, result_err);
    else passed++;

    // Release with start already high, then arm.
    rst = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_arm_busy: got %b want 1", busy);
    else passed++;

    bad = 0;
    for (int i = 0; i < 30; i++) begin
      start_evt = 1'b1;
      stop_evt  = (i == 10);
      @(negedge clk);
      if (dl_sample !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL reset_high_start_no_edge: got %0d bad cycles want 0", bad);
    else passed++;

    do_measure("after_reset", 7, 21, 1, 0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    do_measure("basic", 10, 37, 1, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_measure("timeout", 0, 0, 1, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_no_valid();
    do_measure("no_valid", 6, 9, 99, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_ready();
    do_measure("hold_ready", 5, 12, 2, 8, 1, 1'b0, 1'b0);
    do_measure("after_hold", 3, 50, 1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle();
    do_measure("same_cycle", 4, 44, 1, 0, 1, 1'b1, 1'b0);
  endtask

  task automatic test_boundary();
    do_measure("stop_at_last", TIMEOUT, 5, 1, 0, 0, 1'b0, 1'b0);
    do_measure("stop_too_late", TIMEOUT + 1, 5, 1, 0, 0, 1'b0, 1'b0);
    do_measure("d_one", 1, 63, 1, 0, 0, 1'b0, 1'b0);
    do_measure("valid_last", 8, 17, VALID_WAIT, 0, 0, 1'b0, 1'b0);
    do_measure("valid_late", 8, 17, VALID_WAIT + 1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad;
    start_evt = 1'b0;
    stop_evt  = 1'b0;
    arm       = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    start_evt = 1'b1;
    @(negedge clk);
    repeat (4) begin
      start_evt = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy_before: got %b want 1", busy);
    else passed++;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dl_sample, busy, result_valid, result_coarse, result_fine, result_err} !== '0)
      $display("FAIL reset_mid_outputs: got busy=%b valid=%b coarse=%0d fine=%0d err=%0d want all 0",
               busy, result_valid, result_coarse, result_fine, result_err);
    else passed++;

    bad = 0;
    for (int i = 0; i < 30; i++) begin
      stop_evt = (i % 5 == 2);
      dl_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (dl_sample !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    stop_evt = 1'b0;
    dl_valid = 1'b0;
    checks++;
    if (bad != 0) $display("FAIL reset_mid_quiet: got %0d bad cycles want 0", bad);
    else passed++;
    $display("meas %-12s reset in COUNT -> idle", "reset_mid");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      do_measure("back_to_back", int'($urandom_range(1, 12)), int'($urandom_range(0, 63)),
                 int'($urandom_range(1, VALID_WAIT)), 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      do_measure("random", int'($urandom_range(0, TIMEOUT + 4)), int'($urandom_range(0, 63)),
                 int'($urandom_range(1, VALID_WAIT + 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_no_valid();
    test_hold_ready();
    test_same_cycle();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tdc_measure_ctrl.md
# tdc_measure_ctrl

Measurement sequencer for the time-to-digital converter. It arms on request and detects rising edges of synchronized start and stop events. It counts coarse clock cycles between them, then strobes the delay line's `sample` input and captures its 6-bit fine code. It presents one {coarse, fine, error} result per measurement over a valid/ready handshake to the readout logic.

## Interface
- `COARSE_W`, 16: coarse counter width.
- `FINE_W`, 6: fine code width; matches delay line `fine_count`.
- `TIMEOUT`, 1000: max coarse count before a no-stop abort; 2 ≤ TIMEOUT ≤ 2^COARSE_W.
- `VALID_WAIT`, 3: cycles allowed for delay line `valid` after the sample strobe.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  start a measurement; honoured only in IDLE.
- `start_evt`  in  1  start event, already synchronized to `clk`.
- `stop_evt`  in  1  stop event, already synchronized to `clk`.
- `dl_sample`  out  1  one-cycle strobe to delay line `sample`.
- `dl_valid`  in  1  delay line `valid`.
- `dl_fine`  in  FINE_W  delay line `fine_count`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `result_valid`  out  1  result held and stable.
- `result_ready`  in  1  consumer accepts the result.
- `result_coarse`  out  COARSE_W  coarse cycle count.
- `result_fine`  out  FINE_W  captured fine code.
- `result_err`  out  2  00 ok, 01 no stop (timeout), 10 no fine valid.

## Operation
- Edge detect: `start_prev` and `stop_prev` registers update every cycle in all states. Edge = evt & ~prev. Both reset to 1, so a line already high at reset release is not an edge.
- States: IDLE, WAIT_START, COUNT, SAMPLE, WAIT_VALID, RESULT.
- IDLE: `arm`=1 → WAIT_START. Result registers are not cleared.
- WAIT_START: start edge → COUNT with coarse=0. Waits indefinitely. A stop edge here is ignored, including one in the same cycle as the start edge.
- COUNT: coarse increments by 1 each cycle.
  - Stop edge → SAMPLE. Coarse freezes at its value in the edge cycle.
  - Else if coarse = TIMEOUT−1 → RESULT with err=01, fine=0, coarse=TIMEOUT−1.
  - Stop edge in the same cycle as the timeout condition: stop wins.
- SAMPLE: `dl_sample`=1 for exactly this cycle → WAIT_VALID. A wait counter is cleared.
- WAIT_VALID:
  - `dl_valid`=1 → capture `dl_fine`, err=00 → RESULT.
  - Else after VALID_WAIT cycles in this state → RESULT with err=10, fine=0.
  - `dl_valid` outside WAIT_VALID is ignored.
- RESULT: `result_valid`=1. `result_coarse`, `result_fine` and `result_err` are stable until `result_valid` & `result_ready` → IDLE. `arm` is ignored in RESULT.
- Coarse counter has no wrap. TIMEOUT bounds it below 2^COARSE_W.
- Reset mid-operation: abandons the measurement; no result is emitted.

## Timing
- Reset values: state IDLE; `dl_sample`, `busy`, `result_valid` = 0; `result_coarse`, `result_fine`, `result_err` = 0; `start_prev`, `stop_prev` = 1.
- All outputs are registered or decoded from the Moore state; no combinational input→output path.
- `arm` at cycle a → `busy`=1 at a+1.
- Start edge seen at t, stop edge seen at t+d (d ≥ 1) → `result_coarse` = d−1.
- Stop edge at s → `dl_sample` high at s+1. The delay line returns `dl_valid` at s+2, giving `result_valid`=1 at s+3.
- Handshake completes in cycle h → `result_valid`=0, `busy`=0 at h+1. The earliest next `arm` is honoured at h+1.
- Back-to-back throughput: one measurement per (d + 5) cycles minimum.

## Test plan
- Reset with `start_evt`=1 held high, then arm. Required: no measurement until `start_evt` falls and rises again. All outputs 0 during reset.
- Arm; start edge at t; stop edge at t+10; delay line model returns fine=37 one cycle after `dl_sample`. Required: `result_coarse`=9, `result_fine`=37, err=00, and `result_valid` at stop+3.
- TIMEOUT=20; arm and start with no stop. Required: result coarse=19, fine=0, err=01, and `dl_sample` never asserted.
- Delay line model never asserts `dl_valid`. Required: err=10 exactly VALID_WAIT cycles after entering WAIT_VALID, and coarse is preserved.
- Hold `result_ready`=0 for 8 cycles. Required: result stays stable, `busy`=1, and `arm` pulses are ignored. `result_ready`=1 → IDLE next cycle, and a subsequent arm starts a new measurement.
- Start and stop edges in the same cycle, then a stop edge 4 cycles later. Required: coarse=3. Separately, `rst` asserted in COUNT → IDLE next cycle with no `result_valid`.
